// File: rtl/serial_adder_if.sv
// Handshake/result bundle for the bit-serial adder.
// master drives requests and operands; slave (the adder) returns status and results.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             sum_bit;
  logic             sum_bit_valid;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf, sum_bit, sum_bit_valid
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf, sum_bit, sum_bit_valid
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder slice plus a carry flop, LSB first.
// Streams sum bits as they are produced and publishes sum/cout/ovf on completion.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_q, c_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               sum_bit_q, sum_bit_d;
  logic               sum_bit_valid_q, sum_bit_valid_d;

  logic               s_c;
  logic               c_next_c;

  // Full-adder slice on the current LSBs and the carry flop
  always_comb begin
    s_c      = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    c_next_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
  end

  always_comb begin
    state_d         = state_q;
    a_sh_d          = a_sh_q;
    b_sh_d          = b_sh_q;
    res_d           = res_q;
    cnt_d           = cnt_q;
    c_d             = c_q;
    sum_d           = sum_q;
    cout_d          = cout_q;
    ovf_d           = ovf_q;
    sum_bit_d       = 1'b0;
    sum_bit_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          c_d     = bus.cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d          = a_sh_q >> 1;
        b_sh_d          = b_sh_q >> 1;
        res_d           = WIDTH'({s_c, res_q} >> 1);
        c_d             = c_next_c;
        cnt_d           = CNT_W'(cnt_q + 1'b1);
        sum_bit_d       = s_c;
        sum_bit_valid_d = 1'b1;
        // Final bit: c_q is the carry into the MSB, c_next_c the carry out
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = res_d;
          cout_d  = c_next_c;
          ovf_d   = c_q ^ c_next_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      a_sh_q          <= '0;
      b_sh_q          <= '0;
      res_q           <= '0;
      cnt_q           <= '0;
      c_q             <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      sum_q           <= '0;
      cout_q          <= 1'b0;
      ovf_q           <= 1'b0;
      sum_bit_q       <= 1'b0;
      sum_bit_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      a_sh_q          <= a_sh_d;
      b_sh_q          <= b_sh_d;
      res_q           <= res_d;
      cnt_q           <= cnt_d;
      c_q             <= c_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      sum_q           <= sum_d;
      cout_q          <= cout_d;
      ovf_q           <= ovf_d;
      sum_bit_q       <= sum_bit_d;
      sum_bit_valid_q <= sum_bit_valid_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.sum           = sum_q;
  assign bus.cout          = cout_q;
  assign bus.ovf           = ovf_q;
  assign bus.sum_bit       = sum_bit_q;
  assign bus.sum_bit_valid = sum_bit_valid_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed operations push expected results,
// an independent monitor checks every done pulse and the serial bit stream.
module tb_serial_adder;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst_n;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp  = 0;
  int           n_fail = 0;
  exp_t         exp_q[$];
  logic [W-1:0] prev_sum;
  logic [W-1:0] ser_bits;
  int           ser_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: assemble the serial stream and score each completion
  always @(negedge clk) begin
    if (!rst_n) begin
      ser_bits = '0;
      ser_cnt  = 0;
    end else begin
      if (bus.sum_bit_valid) begin
        ser_bits = {bus.sum_bit, ser_bits[W-1:1]};
        ser_cnt++;
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sum",        32'(bus.sum),  32'(e.sum));
          check("cout",       32'(bus.cout), 32'(e.cout));
          check("ovf",        32'(bus.ovf),  32'(e.ovf));
          check("serial_sum", 32'(ser_bits), 32'(e.sum));
          check("serial_cnt", 32'(ser_cnt),  32'(W));
        end
        ser_bits = '0;
        ser_cnt  = 0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    32'(bus.busy),          32'd0);
    check({tag, "_done"},    32'(bus.done),          32'd0);
    check({tag, "_sum"},     32'(bus.sum),           32'd0);
    check({tag, "_cout"},    32'(bus.cout),          32'd0);
    check({tag, "_ovf"},     32'(bus.ovf),           32'd0);
    check({tag, "_sbit"},    32'(bus.sum_bit),       32'd0);
    check({tag, "_svalid"},  32'(bus.sum_bit_valid), 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                        input logic [W-1:0] esum, input logic ec, input logic eo,
                        input bit repulse, input bit abort);
    int cyc;
    int nbusy;
    exp_t e;
    @(negedge clk);
    bus.a     = ta;
    bus.b     = tb_v;
    bus.cin   = tcin;
    bus.start = 1'b1;
    if (!abort) begin
      e.sum = esum; e.cout = ec; e.ovf = eo;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~ta;
    bus.b     = ~tb_v;
    bus.cin   = ~tcin;
    cyc   = 1;
    nbusy = 0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    while (!bus.done && cyc <= 3 * W) begin
      if (bus.busy) begin
        nbusy++;
        check("sum_hold", 32'(bus.sum), 32'(prev_sum));
      end
      if (abort && cyc == 4) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
          @(negedge clk);
          check("abort_no_done", 32'(bus.done), 32'd0);
          check("abort_idle",    32'(bus.busy), 32'd0);
        end
        prev_sum = '0;
        return;
      end
      if (repulse) begin
        bus.start = (cyc == 3);
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
      end
      @(negedge clk);
      cyc++;
    end
    check("done_latency", 32'(cyc),   32'(W + 1));
    check("busy_cycles",  32'(nbusy), 32'(W));
    check("busy_in_done", 32'(bus.busy), 32'd0);
    prev_sum = esum;
    if (repulse) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("repulse_ignored", 32'(bus.busy), 32'd0);
      repeat (2) begin
        @(negedge clk);
        check("repulse_idle", 32'(bus.busy | bus.done), 32'd0);
      end
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    prev_sum  = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    //      a      b      cin   sum    cout  ovf   repulse abort
    run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
